rf_scrub_arbiter: RTL and testbench

- Sequences background scrubbing of the triplicated (TMR) register file and owns the shared write port.
- Arbitrates the write port between core write-back (always wins) and scrub corrections.
- Walks every register address and reads all three replicas through a dedicated scrub read port.
- Computes the bitwise 2-of-3 majority and writes it back to all replicas when any replica disagrees.

---
 rtl/rf_tmr_pkg.sv | 24 ++
 rtl/tmr_majority_vote.sv | 20 ++
 rtl/rf_scrub_arbiter.sv | 155 +++++++++++++++
 tb/tb_rf_scrub_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_tmr_pkg.sv
// Shared definitions for the TMR register-file blocks: scrub FSM states,
// default widths and the saturating counter increment.
package rf_tmr_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        READ,
        CHECK,
        FIX,
        NEXT
    } scrub_state_t;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/tmr_majority_vote.sv
// Bitwise 2-of-3 majority voter with disagreement flags; purely combinational
// so it can be dropped into any TMR datapath.
module tmr_majority_vote
    import rf_tmr_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] vote,
    output logic              any_mismatch,
    output logic              all_differ
);

    assign vote         = (a & b) | (a & c) | (b & c);
    assign any_mismatch = (a != b) || (a != c);
    assign all_differ   = (a != b) && (a != c) && (b != c);

endmodule

// File: rtl/rf_scrub_arbiter.sv
// Background scrubber for the TMR register file; owns the shared write port.
// Optional per-replica error counters: define RF_SCRUB_REPLICA_STATS_EN.
module rf_scrub_arbiter
    import rf_tmr_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int SCRUB_GAP = 16,
    parameter int ERR_W     = 16
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic              scrub_en,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_waddr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] scrub_raddr,
    input  logic [DATA_W-1:0] scrub_rd_a,
    input  logic [DATA_W-1:0] scrub_rd_b,
    input  logic [DATA_W-1:0] scrub_rd_c,
    output logic              scrub_busy,
    output logic              err_flag,
    output logic [ERR_W-1:0]  err_count,
    output logic              multi_err
`ifdef RF_SCRUB_REPLICA_STATS_EN
    ,
    output logic [ERR_W-1:0]  rep_err_a,
    output logic [ERR_W-1:0]  rep_err_b,
    output logic [ERR_W-1:0]  rep_err_c
`endif
);

    localparam int GAP_W = (SCRUB_GAP > 0) ? $clog2(SCRUB_GAP + 1) : 1;
    localparam logic [GAP_W-1:0]  GAP_END   = GAP_W'(SCRUB_GAP);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    scrub_state_t      state;
    scrub_state_t      state_next;
    logic [GAP_W-1:0]  gap_cnt;
    logic [DATA_W-1:0] vote_w;
    logic              any_mis_w;
    logic              all_diff_w;
    logic [DATA_W-1:0] vote_q;
    logic              any_mis_q;
    logic              all_diff_q;
    logic              core_hit;

    tmr_majority_vote #(
        .DATA_W(DATA_W)
    ) u_vote (
        .a           (scrub_rd_a),
        .b           (scrub_rd_b),
        .c           (scrub_rd_c),
        .vote        (vote_w),
        .any_mismatch(any_mis_w),
        .all_differ  (all_diff_w)
    );

    // A core write to the address under inspection invalidates the sample/correction.
    assign core_hit = core_we && (core_waddr == scrub_raddr);

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (scrub_en) state_next = WAIT;
            WAIT:    if (gap_cnt == GAP_END) state_next = READ;
            READ:    state_next = core_hit ? NEXT : CHECK;
            CHECK:   state_next = any_mis_q ? FIX : NEXT;
            FIX:     if (!core_we || core_hit) state_next = NEXT;
            NEXT:    state_next = scrub_en ? WAIT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            gap_cnt     <= '0;
            scrub_raddr <= '0;
            err_flag    <= 1'b0;
            err_count   <= '0;
        end else begin
            if (state == WAIT) begin
                gap_cnt <= (gap_cnt == GAP_END) ? '0 : gap_cnt + 1'b1;
            end
            if (state == CHECK && any_mis_q) begin
                err_flag  <= 1'b1;
                err_count <= ERR_W'(sat_inc(32'(err_count), ERR_W));
            end
            if (state == NEXT) begin
                scrub_raddr <= (scrub_raddr == LAST_ADDR) ? '0 : scrub_raddr + 1'b1;
            end
        end
    end

    // Sample registers are only consumed in the states following READ, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state == READ) begin
            vote_q     <= vote_w;
            any_mis_q  <= any_mis_w;
            all_diff_q <= all_diff_w;
        end
    end

    assign scrub_busy = (state != IDLE);
    assign multi_err  = (state == CHECK) && any_mis_q && all_diff_q;

    // The core always owns the port when it writes; the scrub fills unused cycles in FIX.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = scrub_raddr;
        rf_wdata = vote_q;
        if (core_we) begin
            rf_we    = 1'b1;
            rf_waddr = core_waddr;
            rf_wdata = core_wdata;
        end else if (state == FIX) begin
            rf_we = 1'b1;
        end
    end

`ifdef RF_SCRUB_REPLICA_STATS_EN
    logic [2:0] rep_diff_q;

    always_ff @(posedge clk) begin
        if (state == READ) begin
            rep_diff_q <= {(scrub_rd_c != vote_w), (scrub_rd_b != vote_w), (scrub_rd_a != vote_w)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            rep_err_a <= '0;
            rep_err_b <= '0;
            rep_err_c <= '0;
        end else if (state == CHECK) begin
            if (rep_diff_q[0]) rep_err_a <= ERR_W'(sat_inc(32'(rep_err_a), ERR_W));
            if (rep_diff_q[1]) rep_err_b <= ERR_W'(sat_inc(32'(rep_err_b), ERR_W));
            if (rep_diff_q[2]) rep_err_c <= ERR_W'(sat_inc(32'(rep_err_c), ERR_W));
        end
    end
`endif

endmodule

// File: tb/tb_rf_scrub_arbiter.sv
// Directed bench for rf_scrub_arbiter with a behavioural three-replica register file.
module tb_rf_scrub_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int EW = 16;

    logic          clk = 1'b0;
    logic          rst_in;
    logic          scrub_en;
    logic          core_we;
    logic [AW-1:0] core_waddr;
    logic [DW-1:0] core_wdata;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] scrub_raddr;
    logic [DW-1:0] scrub_rd_a;
    logic [DW-1:0] scrub_rd_b;
    logic [DW-1:0] scrub_rd_c;
    logic          scrub_busy;
    logic          err_flag;
    logic [EW-1:0] err_count;
    logic          multi_err;
`ifdef RF_SCRUB_REPLICA_STATS_EN
    logic [EW-1:0] rep_err_a;
    logic [EW-1:0] rep_err_b;
    logic [EW-1:0] rep_err_c;
`endif

    always #5 clk = ~clk;

    rf_scrub_arbiter #(
        .NUM_REGS (32),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .SCRUB_GAP(0),
        .ERR_W    (EW)
    ) dut (
        .clk        (clk),
        .rst_in     (rst_in),
        .scrub_en   (scrub_en),
        .core_we    (core_we),
        .core_waddr (core_waddr),
        .core_wdata (core_wdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .scrub_raddr(scrub_raddr),
        .scrub_rd_a (scrub_rd_a),
        .scrub_rd_b (scrub_rd_b),
        .scrub_rd_c (scrub_rd_c),
        .scrub_busy (scrub_busy),
        .err_flag   (err_flag),
        .err_count  (err_count),
        .multi_err  (multi_err)
`ifdef RF_SCRUB_REPLICA_STATS_EN
        ,
        .rep_err_a  (rep_err_a),
        .rep_err_b  (rep_err_b),
        .rep_err_c  (rep_err_c)
`endif
    );

    // Replica model: preload requests from the stimulus, otherwise the shared write port.
    logic [DW-1:0] rep_a [32];
    logic [DW-1:0] rep_b [32];
    logic [DW-1:0] rep_c [32];
    logic          pl_go = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_a = '0;
    logic [DW-1:0] pl_b = '0;
    logic [DW-1:0] pl_c = '0;
    int            wr_cnt = 0;
    int            multi_cnt = 0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [DW-1:0] last_wr_data = '0;

    assign scrub_rd_a = rep_a[scrub_raddr];
    assign scrub_rd_b = rep_b[scrub_raddr];
    assign scrub_rd_c = rep_c[scrub_raddr];

    always @(negedge clk) begin
        if (pl_go) begin
            rep_a[pl_addr] = pl_a;
            rep_b[pl_addr] = pl_b;
            rep_c[pl_addr] = pl_c;
        end else if (rf_we) begin
            rep_a[rf_waddr] = rf_wdata;
            rep_b[rf_waddr] = rf_wdata;
            rep_c[rf_waddr] = rf_wdata;
        end
        if (rf_we && !core_we) begin
            wr_cnt++;
            last_wr_addr = rf_waddr;
            last_wr_data = rf_wdata;
        end
        if (multi_err) multi_cnt++;
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst_in     = 1'b1;
        scrub_en   = 1'b0;
        core_we    = 1'b0;
        core_waddr = '0;
        core_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst_in = 1'b0;
    endtask

    task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] va,
                           input logic [DW-1:0] vb, input logic [DW-1:0] vc);
        pl_addr = addr;
        pl_a    = va;
        pl_b    = vb;
        pl_c    = vc;
        pl_go   = 1'b1;
        @(negedge clk);
        #1 pl_go = 1'b0;
    endtask

    task automatic fill_clean();
        logic [DW-1:0] v;
        for (int i = 0; i < 32; i++) begin
            v = {4{i[7:0]}};
            preload(AW'(i), v, v, v);
        end
    endtask

    // Returns at the negedge of the first cycle showing the address (the WAIT cycle).
    task automatic wait_addr(input string tag, input logic [AW-1:0] addr);
        int n;
        n = 0;
        @(negedge clk);
        while (scrub_raddr !== addr && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(scrub_raddr), 32'(addr));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (scrub_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(scrub_busy), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int m0;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_raddr", 32'(scrub_raddr), 32'(0));
        check("rst_rf_we", 32'(rf_we), 32'(0));
        check("rst_busy", 32'(scrub_busy), 32'(0));
        check("rst_err_flag", 32'(err_flag), 32'(0));
        check("rst_err_count", 32'(err_count), 32'(0));
        check("rst_multi", 32'(multi_err), 32'(0));

        // Clean sweep with wrap, then stop and resume
        fill_clean();
        w0 = wr_cnt;
        #1 scrub_en = 1'b1;
        wait_addr("sweep_reach_31", 5'd31);
        wait_addr("sweep_wrap_0", 5'd0);
        #1;
        check("sweep_no_scrub_wr", 32'(wr_cnt - w0), 32'(0));
        check("sweep_err_count", 32'(err_count), 32'(0));
        check("sweep_err_flag", 32'(err_flag), 32'(0));
        scrub_en = 1'b0;
        wait_idle("stop_idle");
        check("stop_raddr_kept", 32'(scrub_raddr), 32'(1));
        #1 scrub_en = 1'b1;
        wait_addr("resume_reach_2", 5'd2);
        #1 scrub_en = 1'b0;

        // Single flip in replica b of reg 5
        do_reset();
        fill_clean();
        preload(5'd5, 32'h5, 32'h4, 32'h5);
        w0 = wr_cnt;
        m0 = multi_cnt;
        scrub_en = 1'b1;
        wait_addr("flip_reach_8", 5'd8);
        #1;
        check("flip_wr_cnt", 32'(wr_cnt - w0), 32'(1));
        check("flip_wr_addr", 32'(last_wr_addr), 32'(5));
        check("flip_wr_data", last_wr_data, 32'h5);
        check("flip_err_count", 32'(err_count), 32'(1));
        check("flip_err_flag", 32'(err_flag), 32'(1));
        check("flip_rep_b", rep_b[5], 32'h5);
        check("flip_no_multi", 32'(multi_cnt - m0), 32'(0));

        // Core priority: FIX at reg 7 stalled by three core writes to reg 9
        do_reset();
        fill_clean();
        preload(5'd7, 32'h77, 32'h77, 32'h70);
        w0 = wr_cnt;
        scrub_en = 1'b1;
        wait_addr("pri_reach_7", 5'd7);
        repeat (3) @(posedge clk);
        #1;
        core_we    = 1'b1;
        core_waddr = 5'd9;
        core_wdata = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("pri_core_we", 32'(rf_we), 32'(1));
            check("pri_core_addr", 32'(rf_waddr), 32'(9));
            check("pri_core_data", rf_wdata, 32'h1234_5678);
            @(posedge clk);
            #1;
        end
        core_we = 1'b0;
        @(negedge clk);
        check("pri_scrub_we", 32'(rf_we), 32'(1));
        check("pri_scrub_addr", 32'(rf_waddr), 32'(7));
        check("pri_scrub_data", rf_wdata, 32'h77);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("pri_single_write", 32'(rf_we), 32'(0));
        #1;
        check("pri_wr_cnt", 32'(wr_cnt - w0), 32'(1));
        check("pri_rep_c", rep_c[7], 32'h77);
        check("pri_rep_9", rep_a[9], 32'h1234_5678);

        // Supersede: core writes the pending address during FIX
        do_reset();
        fill_clean();
        preload(5'd3, 32'h33, 32'h31, 32'h33);
        w0 = wr_cnt;
        scrub_en = 1'b1;
        wait_addr("sup_reach_3", 5'd3);
        repeat (3) @(posedge clk);
        #1;
        core_we    = 1'b1;
        core_waddr = 5'd3;
        core_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("sup_core_we", 32'(rf_we), 32'(1));
        check("sup_core_data", rf_wdata, 32'hDEAD_BEEF);
        @(posedge clk);
        #1 core_we = 1'b0;
        @(negedge clk);
        check("sup_no_scrub_we", 32'(rf_we), 32'(0));
        wait_addr("sup_reach_5", 5'd5);
        #1;
        check("sup_wr_cnt", 32'(wr_cnt - w0), 32'(0));
        check("sup_err_count", 32'(err_count), 32'(1));
        check("sup_rep_b", rep_b[3], 32'hDEAD_BEEF);

        // All three replicas differ at reg 10
        do_reset();
        fill_clean();
        preload(5'd10, 32'h1, 32'h2, 32'h4);
        m0 = multi_cnt;
        scrub_en = 1'b1;
        wait_addr("multi_reach_10", 5'd10);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("multi_pulse", 32'(multi_err), 32'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("multi_pulse_end", 32'(multi_err), 32'(0));
        check("multi_fix_we", 32'(rf_we), 32'(1));
        check("multi_fix_addr", 32'(rf_waddr), 32'(10));
        check("multi_fix_data", rf_wdata, 32'h0);
        wait_addr("multi_reach_12", 5'd12);
        #1;
        check("multi_cnt", 32'(multi_cnt - m0), 32'(1));
        check("multi_err_count", 32'(err_count), 32'(1));
        check("multi_rep_a", rep_a[10], 32'h0);

        // Reset while a correction is pending and the core holds the port
        do_reset();
        fill_clean();
        preload(5'd12, 32'hC, 32'hC, 32'hF);
        w0 = wr_cnt;
        scrub_en = 1'b1;
        wait_addr("rfix_reach_12", 5'd12);
        repeat (3) @(posedge clk);
        #1;
        core_we    = 1'b1;
        core_waddr = 5'd20;
        core_wdata = 32'hA5A5_A5A5;
        rst_in     = 1'b1;
        @(negedge clk);
        check("rfix_core_addr", 32'(rf_waddr), 32'(20));
        @(posedge clk);
        #1;
        rst_in   = 1'b0;
        core_we  = 1'b0;
        scrub_en = 1'b0;
        @(negedge clk);
        check("rfix_raddr", 32'(scrub_raddr), 32'(0));
        check("rfix_rf_we", 32'(rf_we), 32'(0));
        check("rfix_busy", 32'(scrub_busy), 32'(0));
        check("rfix_err_flag", 32'(err_flag), 32'(0));
        check("rfix_err_count", 32'(err_count), 32'(0));
        check("rfix_multi", 32'(multi_err), 32'(0));
        repeat (3) @(negedge clk);
        #1;
        check("rfix_no_scrub_wr", 32'(wr_cnt - w0), 32'(0));
        check("rfix_rep_c_kept", rep_c[12], 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
